imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_if.sv | 28 ++
 rtl/imm_extend_pipe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/imm_extend_if.sv
// Request/result bundle for the immediate-extension pipe.
// The master drives requests and result acceptance; the slave is the pipe itself.
interface imm_extend_if #(
    parameter int XLEN = 32,
    parameter int TAGW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [31:7]     instr;
    logic [2:0]      immsrc;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] immext;
    logic [TAGW-1:0] out_tag;
    logic            out_err;
    logic [7:0]      err_count;

    modport master (
        output in_valid, instr, immsrc, in_tag, out_ready,
        input  in_ready, out_valid, immext, out_tag, out_err, err_count
    );

    modport slave (
        input  in_valid, instr, immsrc, in_tag, out_ready,
        output in_ready, out_valid, immext, out_tag, out_err, err_count
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// RISC-V immediate extension with a 2-entry in-order result FIFO.
// The FIFO is a head/tail register pair so the outputs come straight from
// flops; the head is cleared whenever it empties so idle outputs read zero.
module imm_extend_pipe #(
    parameter int XLEN = 32,
    parameter int TAGW = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    imm_extend_if.slave bus
);
    localparam int EW = XLEN + TAGW + 1;

    logic [XLEN-1:0] imm_s;
    logic            err_s;
    logic            sign_s;
    logic [EW-1:0]   entry_s;
    logic            push_s;
    logic            pop_s;

    logic [1:0]      count_r;
    logic [1:0]      count_nxt_s;
    logic [EW-1:0]   head_r;
    logic [EW-1:0]   head_nxt_s;
    logic [EW-1:0]   tail_r;
    logic [EW-1:0]   tail_nxt_s;
    logic            valid_r;
    logic            ready_r;
    logic [7:0]      err_count_r;
    logic [7:0]      err_count_nxt_s;

    // Decode the immediate format selected by immsrc into an XLEN-wide value.
    always_comb begin
        sign_s = bus.instr[31];
        imm_s  = {XLEN{1'b0}};
        err_s  = 1'b0;
        case (bus.immsrc)
            3'b000: begin
                imm_s        = {XLEN{sign_s}};
                imm_s[11:0]  = bus.instr[31:20];
            end
            3'b001: begin
                imm_s        = {XLEN{sign_s}};
                imm_s[11:0]  = {bus.instr[31:25], bus.instr[11:7]};
            end
            3'b010: begin
                imm_s        = {XLEN{sign_s}};
                imm_s[12:0]  = {sign_s, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
            end
            3'b011: begin
                imm_s        = {XLEN{sign_s}};
                imm_s[31:0]  = {bus.instr[31:12], 12'd0};
            end
            3'b100: begin
                imm_s        = {XLEN{sign_s}};
                imm_s[20:0]  = {sign_s, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
            end
            3'b101: begin
                imm_s[4:0]   = bus.instr[19:15];
            end
            3'b110: begin
                // RV64 shift amounts carry one extra bit.
                if (XLEN == 64) begin
                    imm_s[5:0] = bus.instr[25:20];
                end else begin
                    imm_s[4:0] = bus.instr[24:20];
                end
            end
            3'b111: begin
                err_s = 1'b1;
            end
            default: begin
                err_s = 1'b1;
            end
        endcase
    end

    assign entry_s = {imm_s, bus.in_tag, err_s};
    assign push_s  = bus.in_valid && ready_r;
    assign pop_s   = valid_r && bus.out_ready;

    // FIFO next-state: accept/consume combinations over the head/tail pair.
    always_comb begin
        count_nxt_s = count_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case ({push_s, pop_s})
            2'b10: begin
                case (count_r)
                    2'd0: begin
                        head_nxt_s  = entry_s;
                        count_nxt_s = 2'd1;
                    end
                    2'd1: begin
                        tail_nxt_s  = entry_s;
                        count_nxt_s = 2'd2;
                    end
                    default: begin
                        count_nxt_s = count_r;
                    end
                endcase
            end
            2'b01: begin
                if (count_r == 2'd2) begin
                    head_nxt_s  = tail_r;
                    tail_nxt_s  = {EW{1'b0}};
                    count_nxt_s = 2'd1;
                end else begin
                    head_nxt_s  = {EW{1'b0}};
                    count_nxt_s = 2'd0;
                end
            end
            2'b11: begin
                // Only reachable with one entry: the new request becomes head.
                head_nxt_s = entry_s;
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Saturating count of accepted illegal-format requests.
    always_comb begin
        if (push_s && (bus.immsrc == 3'b111) && (err_count_r != 8'd255)) begin
            err_count_nxt_s = err_count_r + 8'd1;
        end else begin
            err_count_nxt_s = err_count_r;
        end
    end

    // FIFO storage, occupancy flags and error counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r     <= 2'd0;
            head_r      <= {EW{1'b0}};
            tail_r      <= {EW{1'b0}};
            valid_r     <= 1'b0;
            ready_r     <= 1'b1;
            err_count_r <= 8'd0;
        end else begin
            count_r     <= count_nxt_s;
            head_r      <= head_nxt_s;
            tail_r      <= tail_nxt_s;
            valid_r     <= (count_nxt_s != 2'd0);
            ready_r     <= (count_nxt_s != 2'd2);
            err_count_r <= err_count_nxt_s;
        end
    end

    assign bus.in_ready  = ready_r;
    assign bus.out_valid = valid_r;
    assign bus.immext    = head_r[EW-1 -: XLEN];
    assign bus.out_tag   = head_r[TAGW:1];
    assign bus.out_err   = head_r[0];
    assign bus.err_count = err_count_r;
endmodule
